// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback path.
package wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    // One queued register write: destination and value.
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Result-source handshakes, register-file write port and hazard query bundle.
interface writeback_unit_if #(parameter int DEPTH = 4);
    import wb_pkg::*;

    localparam int CNT_W = cnt_width(DEPTH);

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;

    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic              rs1_busy;
    logic              rs2_busy;

    logic [CNT_W-1:0]  fifo_count;

    // The writeback unit sits on the slave side; producers/consumers on master.
    modport slave (
        input  mem_valid, mem_rd, mem_data,
        input  alu_valid, alu_rd, alu_data,
        input  rs1_addr, rs2_addr,
        output mem_ready, alu_ready,
        output wb_en, wb_addr, wb_data,
        output rs1_busy, rs2_busy, fifo_count
    );

    modport master (
        output mem_valid, mem_rd, mem_data,
        output alu_valid, alu_rd, alu_data,
        output rs1_addr, rs2_addr,
        input  mem_ready, alu_ready,
        input  wb_en, wb_addr, wb_data,
        input  rs1_busy, rs2_busy, fifo_count
    );

endinterface

// File: rtl/wb_fifo.sv
// Result FIFO: up to two pushes per cycle (port A lands first), one pop.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_a_i,
    input  wb_entry_t        entry_a_i,
    input  logic             push_b_i,
    input  wb_entry_t        entry_b_i,
    input  logic             pop_i,
    output wb_entry_t        head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] slot_b;
    logic [1:0]       n_push;
    logic             pop_eff;

    // Pointer wrap that also works for non power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    always_comb begin
        n_push   = {1'b0, push_a_i} + {1'b0, push_b_i};
        pop_eff  = pop_i && (count_q != '0);
        slot_b   = push_a_i ? ptr_add(wr_ptr_q, 1) : wr_ptr_q;
        wr_ptr_d = ptr_add(wr_ptr_q, int'(n_push));
        rd_ptr_d = pop_eff ? ptr_add(rd_ptr_q, 1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(n_push) - CNT_W'(pop_eff);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_a_i) mem_q[wr_ptr_q] <= entry_a_i;
        if (push_b_i) mem_q[slot_b]   <= entry_b_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/writeback_unit.sv
// Register-file write initiator: in-order result queue, one write per cycle,
// and a per-register pending-write scoreboard for operand hazard checks.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    writeback_unit_if.slave  bus
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int SB_W  = $clog2(DEPTH + 3);

    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    free;
    logic                mem_ready, alu_ready;
    logic                mem_acc, alu_acc;
    logic                pop;
    wb_entry_t           mem_entry, alu_entry, head;

    logic                wb_en_q, wb_en_d;
    logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [NUM_REGS-1:0] pending;

    // Readiness comes from the registered count only; a same-cycle pop earns no credit.
    assign free      = CNT_W'(DEPTH) - count;
    assign mem_ready = (free >= CNT_W'(1));
    assign alu_ready = (free >= CNT_W'(2)) || ((free >= CNT_W'(1)) && !bus.mem_valid);
    assign mem_acc   = bus.mem_valid && mem_ready;
    assign alu_acc   = bus.alu_valid && alu_ready;
    assign pop       = (count != '0);

    assign mem_entry = {bus.mem_rd, bus.mem_data};
    assign alu_entry = {bus.alu_rd, bus.alu_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_a_i  (mem_acc),
        .entry_a_i (mem_entry),
        .push_b_i  (alu_acc),
        .entry_b_i (alu_entry),
        .pop_i     (pop),
        .head_o    (head),
        .count_o   (count)
    );

    always_comb begin
        wb_en_d   = pop;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (pop) begin
            wb_addr_d = head.rd;
            wb_data_d = head.data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    // A counter covers results both in the FIFO and sitting in the wb register.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
        logic [SB_W-1:0] cnt_q, cnt_d;
        logic [1:0]      inc;
        logic            dec;

        always_comb begin
            inc   = {1'b0, mem_acc && (bus.mem_rd == ADDR_W'(r))}
                  + {1'b0, alu_acc && (bus.alu_rd == ADDR_W'(r))};
            dec   = wb_en_q && (wb_addr_q == ADDR_W'(r));
            cnt_d = cnt_q + SB_W'(inc) - SB_W'(dec);
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) cnt_q <= '0;
            else       cnt_q <= cnt_d;
        end

        assign pending[r] = (cnt_q != '0);
    end

    assign bus.mem_ready  = mem_ready;
    assign bus.alu_ready  = alu_ready;
    assign bus.wb_en      = wb_en_q;
    assign bus.wb_addr    = wb_addr_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.rs1_busy   = pending[bus.rs1_addr];
    assign bus.rs2_busy   = pending[bus.rs2_addr];
    assign bus.fifo_count = count;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: scoreboard queue of expected writes, vector table for fill.
module tb_writeback_unit;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic              mv;
        logic [ADDR_W-1:0] mrd;
        logic [DATA_W-1:0] mdat;
        logic              av;
        logic [ADDR_W-1:0] ard;
        logic [DATA_W-1:0] adat;
        logic              exp_mr;
        logic              exp_ar;
        int                exp_cnt;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    writeback_unit_if #(.DEPTH(DEPTH)) bus();

    writeback_unit #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int        checks   = 0;
    int        errors   = 0;
    int        prev_cnt = 0;
    wb_entry_t exp_q[$];
    vec_t      fill_tbl[9];

    // Stalled sources must hold their request until accepted.
    logic      mem_stall_q = 1'b0, alu_stall_q = 1'b0;
    wb_entry_t mem_last_q, alu_last_q;
    always @(posedge clk) begin
        if (!reset && mem_stall_q && (bus.mem_valid !== 1'b1 || {bus.mem_rd, bus.mem_data} !== mem_last_q))
            $error("mem input changed while stalled");
        if (!reset && alu_stall_q && (bus.alu_valid !== 1'b1 || {bus.alu_rd, bus.alu_data} !== alu_last_q))
            $error("alu input changed while stalled");
        mem_stall_q <= bus.mem_valid && !bus.mem_ready;
        alu_stall_q <= bus.alu_valid && !bus.alu_ready;
        mem_last_q  <= {bus.mem_rd, bus.mem_data};
        alu_last_q  <= {bus.alu_rd, bus.alu_data};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] mdat,
                         input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] adat);
        bus.mem_valid = mv;  bus.mem_rd = mrd;  bus.mem_data = mdat;
        bus.alu_valid = av;  bus.alu_rd = ard;  bus.alu_data = adat;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // One clock: check readiness, queue accepted results, then check the write port.
    task automatic step(input string tag, input logic exp_mr, input logic exp_ar, input int exp_cnt);
        wb_entry_t e;
        #1;
        chk({tag, " mem_ready"}, 64'(bus.mem_ready), 64'(exp_mr));
        chk({tag, " alu_ready"}, 64'(bus.alu_ready), 64'(exp_ar));
        if (bus.mem_valid && exp_mr) exp_q.push_back({bus.mem_rd, bus.mem_data});
        if (bus.alu_valid && exp_ar) exp_q.push_back({bus.alu_rd, bus.alu_data});
        @(posedge clk);
        @(negedge clk);
        #1;
        chk({tag, " wb_en"}, 64'(bus.wb_en), 64'(prev_cnt != 0));
        if (prev_cnt != 0 && bus.wb_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s wb_order: write issued with empty expected queue", tag);
            end else begin
                e = exp_q.pop_front();
                chk({tag, " wb_addr"}, 64'(bus.wb_addr), 64'(e.rd));
                chk({tag, " wb_data"}, 64'(bus.wb_data), 64'(e.data));
            end
        end
        chk({tag, " fifo_count"}, 64'(bus.fifo_count), 64'(exp_cnt));
        prev_cnt = exp_cnt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        fill_tbl[0] = '{1'b1, 4'd1,  32'h101, 1'b1, 4'd2, 32'h202, 1'b1, 1'b1, 2};
        fill_tbl[1] = '{1'b1, 4'd4,  32'h104, 1'b1, 4'd6, 32'h206, 1'b1, 1'b1, 3};
        fill_tbl[2] = '{1'b1, 4'd8,  32'h108, 1'b1, 4'd9, 32'h209, 1'b1, 1'b0, 3};
        fill_tbl[3] = '{1'b1, 4'd10, 32'h10a, 1'b1, 4'd9, 32'h209, 1'b1, 1'b0, 3};
        fill_tbl[4] = '{1'b0, 4'd0,  32'h0,   1'b1, 4'd9, 32'h209, 1'b1, 1'b1, 3};
        fill_tbl[5] = '{1'b0, 4'd0,  32'h0,   1'b0, 4'd0, 32'h0,   1'b1, 1'b1, 2};
        fill_tbl[6] = '{1'b0, 4'd0,  32'h0,   1'b0, 4'd0, 32'h0,   1'b1, 1'b1, 1};
        fill_tbl[7] = '{1'b0, 4'd0,  32'h0,   1'b0, 4'd0, 32'h0,   1'b1, 1'b1, 0};
        fill_tbl[8] = '{1'b0, 4'd0,  32'h0,   1'b0, 4'd0, 32'h0,   1'b1, 1'b1, 0};

        idle();
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;

        // Reset state
        #1;
        chk("rst wb_en",      64'(bus.wb_en), 64'd0);
        chk("rst wb_addr",    64'(bus.wb_addr), 64'd0);
        chk("rst wb_data",    64'(bus.wb_data), 64'd0);
        chk("rst fifo_count", 64'(bus.fifo_count), 64'd0);
        chk("rst rs1_busy",   64'(bus.rs1_busy), 64'd0);
        chk("rst mem_ready",  64'(bus.mem_ready), 64'd1);
        chk("rst alu_ready",  64'(bus.alu_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Single ALU push and its latency / busy window
        bus.rs1_addr = 4'd5;
        drive(1'b0, '0, '0, 1'b1, 4'd5, 32'hDEADBEEF);
        step("single_a", 1'b1, 1'b1, 1);
        chk("single rs1_busy after accept", 64'(bus.rs1_busy), 64'd1);
        idle();
        step("single_b", 1'b1, 1'b1, 0);
        chk("single rs1_busy during write", 64'(bus.rs1_busy), 64'd1);
        step("single_c", 1'b1, 1'b1, 0);
        chk("single rs1_busy after retire", 64'(bus.rs1_busy), 64'd0);

        // Both sources to r3 in one cycle: mem first, counter reaches 2
        bus.rs2_addr = 4'd3;
        drive(1'b1, 4'd3, 32'h11, 1'b1, 4'd3, 32'h22);
        step("dual_a", 1'b1, 1'b1, 2);
        chk("dual rs2_busy a", 64'(bus.rs2_busy), 64'd1);
        idle();
        step("dual_b", 1'b1, 1'b1, 1);
        chk("dual rs2_busy b", 64'(bus.rs2_busy), 64'd1);
        step("dual_c", 1'b1, 1'b1, 0);
        chk("dual rs2_busy c", 64'(bus.rs2_busy), 64'd1);
        step("dual_d", 1'b1, 1'b1, 0);
        chk("dual rs2_busy d", 64'(bus.rs2_busy), 64'd0);

        // Accept on the same edge that retires an older write to r7
        bus.rs1_addr = 4'd7;
        drive(1'b0, '0, '0, 1'b1, 4'd7, 32'hA7);
        step("r7_a", 1'b1, 1'b1, 1);
        idle();
        step("r7_b", 1'b1, 1'b1, 0);
        drive(1'b0, '0, '0, 1'b1, 4'd7, 32'hB7);
        step("r7_c", 1'b1, 1'b1, 1);
        chk("r7 rs1_busy net zero", 64'(bus.rs1_busy), 64'd1);
        idle();
        step("r7_d", 1'b1, 1'b1, 0);
        chk("r7 rs1_busy d", 64'(bus.rs1_busy), 64'd1);
        step("r7_e", 1'b1, 1'b1, 0);
        chk("r7 rs1_busy e", 64'(bus.rs1_busy), 64'd0);

        // Fill toward DEPTH with both sources valid
        for (int i = 0; i < 9; i++) begin
            drive(fill_tbl[i].mv, fill_tbl[i].mrd, fill_tbl[i].mdat,
                  fill_tbl[i].av, fill_tbl[i].ard, fill_tbl[i].adat);
            step($sformatf("fill%0d", i), fill_tbl[i].exp_mr, fill_tbl[i].exp_ar, fill_tbl[i].exp_cnt);
        end

        // Back-to-back single-source stream
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, '0, 1'b1, 4'((i * 3) % 16), $urandom);
            step($sformatf("stream%0d", i), 1'b1, 1'b1, 1);
        end
        idle();
        step("stream_drain", 1'b1, 1'b1, 0);
        step("stream_idle", 1'b1, 1'b1, 0);

        // Reset asserted mid-stream with three entries queued
        bus.rs1_addr = 4'd13;
        bus.rs2_addr = 4'd14;
        drive(1'b1, 4'd11, 32'h301, 1'b1, 4'd12, 32'h302);
        step("mrst_a", 1'b1, 1'b1, 2);
        drive(1'b1, 4'd13, 32'h303, 1'b1, 4'd14, 32'h304);
        step("mrst_b", 1'b1, 1'b1, 3);
        idle();
        chk("mrst rs1_busy before", 64'(bus.rs1_busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mrst wb_en async",      64'(bus.wb_en), 64'd0);
        chk("mrst fifo_count async", 64'(bus.fifo_count), 64'd0);
        chk("mrst rs1_busy async",   64'(bus.rs1_busy), 64'd0);
        exp_q.delete();
        prev_cnt = 0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("post_rst%0d", i), 1'b1, 1'b1, 0);
            chk("post_rst rs1_busy", 64'(bus.rs1_busy), 64'd0);
            chk("post_rst rs2_busy", 64'(bus.rs2_busy), 64'd0);
        end

        chk("leftover expected writes", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
